// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: a single shared inverse-round datapath with a registered
// inverse S-box stage. Round keys come from an external 1-cycle-latency RAM.
//
// state | meaning
// IDLE  | waiting for a ciphertext block, rk_idx parked at NR
// ARK0  | initial AddRoundKey with rk[NR]
// SUB   | InvShiftRows + InvSubBytes into sb_reg, rk_idx = round
// MIX   | AddRoundKey rk[round], InvMixColumns unless round 0
// DONE  | plaintext presented, waiting for out_ready
module aes_inv_cipher_iter #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [IDX_W-1:0] rk_idx,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ARK0, SUB, MIX, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

  state_t           state, state_nx;
  logic [127:0]     st, st_nx;
  logic [127:0]     sb_reg, sb_nx;
  logic [127:0]     ark_t;
  logic [IDX_W-1:0] round, round_nx;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign ark_t    = sb_reg ^ rk_data;
  assign out_data = st;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      st     <= '0;
      sb_reg <= '0;
      round  <= LAST;
    end else begin
      state  <= state_nx;
      st     <= st_nx;
      sb_reg <= sb_nx;
      round  <= round_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    st_nx     = st;
    sb_nx     = sb_reg;
    round_nx  = round;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = LAST;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nx    = in_data;
          round_nx = LAST;
          state_nx = ARK0;
        end
      end
      ARK0: begin
        st_nx    = st ^ rk_data;
        round_nx = LAST - 1'b1;
        state_nx = SUB;
      end
      SUB: begin
        rk_idx   = round;
        sb_nx    = inv_shift_sub(st);
        state_nx = MIX;
      end
      MIX: begin
        rk_idx = round;
        if (round != '0) begin
          st_nx    = inv_mix_columns(ark_t);
          round_nx = round - 1'b1;
          state_nx = SUB;
        end else begin
          st_nx    = ark_t;
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: key-RAM model, forward-cipher reference model, and a
// scoreboard queue of expected plaintexts checked as results appear.
module tb_aes_inv_cipher_iter;
  localparam int NR    = 10;
  localparam int IDX_W = 4;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [127:0]     in_data = '0;
  logic             in_ready, out_valid, busy;
  logic [IDX_W-1:0] rk_idx;
  logic [127:0]     rk_data, out_data;

  logic [127:0] key_ram [0:15];
  logic [127:0] exp_q [$];
  int n_pass = 0;
  int n_total = 0;

  aes_inv_cipher_iter #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rk_data <= key_ram[rk_idx];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p = a;
    logic [7:0] r = 8'h01;
    logic [7:0] b;
    for (int i = 1; i < 8; i++) begin
      p = mul(p, p);
      r = mul(r, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input bit last);
    logic [127:0] o;
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    if (last) return o;
    for (int c = 0; c < 4; c++) begin
      a0 = o[127-32*c -: 8];
      a1 = o[119-32*c -: 8];
      a2 = o[111-32*c -: 8];
      a3 = o[103-32*c -: 8];
      m[127-32*c -: 8] = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
      m[119-32*c -: 8] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
      m[111-32*c -: 8] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
      m[103-32*c -: 8] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
    end
    return m;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s = pt ^ key_ram[0];
    for (int r = 1; r <= NR; r++) s = enc_round(s, r == NR) ^ key_ram[r];
    return s;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) key_ram[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = NR + 1; r < 16; r++) key_ram[r] = '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drives one block at a negedge where in_ready is high; returns at the negedge after accept.
  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = ct;
    exp_q.push_back(pt);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit trace, output int edges);
    edges = 0;
    if (trace) chk("rk_idx_ark0", rk_idx, NR);
    while (!out_valid && edges < 60) begin
      @(negedge clk);
      edges++;
      if (trace && !out_valid) begin
        chk("busy_running", busy, 1'b1);
        if (edges % 2 == 1) chk($sformatf("rk_idx_sub_e%0d", edges), rk_idx, NR - 1 - (edges - 1) / 2);
      end
    end
    if (trace) chk("rk_idx_done", rk_idx, NR);
  endtask

  task automatic take_out(input string tag);
    logic [127:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk(tag, out_data, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int e;
    logic [127:0] pts [0:7];
    logic [127:0] cts [0:7];

    load_key(C1_KEY);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rk_idx", rk_idx, NR);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("idle_rk_idx", rk_idx, NR);

    send(C1_CT, C1_PT);
    wait_out(1'b1, e);
    chk("c1_latency", e, 2 * NR + 1);
    take_out("c1_data");

    load_key(B_KEY);
    send(B_CT, B_PT);
    wait_out(1'b0, e);
    chk("b_latency", e, 2 * NR + 1);
    take_out("b_data");

    load_key(C1_KEY);
    send(C1_CT, C1_PT);
    wait_out(1'b0, e);
    in_valid = 1'b1;
    in_data  = B_CT;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", out_data, C1_PT);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    take_out("bp_release");
    chk("bp_busy_after", busy, 1'b0);

    load_key(B_KEY);
    for (int i = 0; i < 8; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      cts[i] = encrypt(pts[i]);
    end
    begin
      int idx = 0, got = 0, acc = 0, cyc = 0, last_acc = -1;
      bit pend = 1'b0;
      in_valid  = 1'b1;
      in_data   = cts[0];
      out_ready = 1'b1;
      while (got < 8 && cyc < 400) begin
        if (out_valid) begin
          chk($sformatf("b2b_data_%0d", got), out_data, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
          got++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(pts[idx]);
          if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 2 * NR + 3);
          last_acc = cyc;
          acc++;
          pend = 1'b1;
        end
        @(negedge clk);
        cyc++;
        if (pend) begin
          pend = 1'b0;
          idx++;
          if (idx < 8) in_data = cts[idx];
          else in_valid = 1'b0;
        end
      end
      out_ready = 1'b0;
      chk("b2b_results", got, 8);
      chk("b2b_accepts", acc, 8);
    end

    load_key(C1_KEY);
    send(C1_CT, C1_PT);
    repeat (9) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_data", out_data, '0);
    chk("async_busy", busy, 1'b0);
    chk("async_rk_idx", rk_idx, NR);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(C1_CT, C1_PT);
    wait_out(1'b0, e);
    chk("post_rst_latency", e, 2 * NR + 1);
    take_out("post_rst_data");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
